// File: rtl/dbg_apb_core_slave.sv
// Core-side debug APB responder: small debug register file plus run-control
// pulses and a req/ack GPR side channel towards the core.
module dbg_apb_core_slave #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned APB_ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [31:0] ID_VALUE       = 32'h7AC1_0001,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [APB_ADDR_WIDTH-1:0] apb_addr,
  input  logic                      apb_sel,
  input  logic                      apb_enable,
  input  logic                      apb_wr_rd,
  input  logic [DATA_WIDTH-1:0]     apb_wdata,
  output logic                      apb_ready,
  output logic [DATA_WIDTH-1:0]     apb_rdata,
  output logic                      halt_req,
  output logic                      resume_req,
  output logic                      step_req,
  input  logic                      core_halted,
  input  logic [ADDR_WIDTH-1:0]     core_pc,
  output logic                      reg_req,
  output logic                      reg_we,
  output logic [4:0]                reg_idx,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  input  logic                      reg_ack,
  input  logic [DATA_WIDTH-1:0]     reg_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT_CORE} state_t;

  localparam logic [APB_ADDR_WIDTH-1:0] A_ID       = APB_ADDR_WIDTH'(0);
  localparam logic [APB_ADDR_WIDTH-1:0] A_CTRL     = APB_ADDR_WIDTH'(1);
  localparam logic [APB_ADDR_WIDTH-1:0] A_STATUS   = APB_ADDR_WIDTH'(2);
  localparam logic [APB_ADDR_WIDTH-1:0] A_PC       = APB_ADDR_WIDTH'(3);
  localparam logic [APB_ADDR_WIDTH-1:0] A_GPR_IDX  = APB_ADDR_WIDTH'(4);
  localparam logic [APB_ADDR_WIDTH-1:0] A_GPR_DATA = APB_ADDR_WIDTH'(5);
  localparam logic [APB_ADDR_WIDTH-1:0] A_SCRATCH  = APB_ADDR_WIDTH'(6);
  // Timeout fires on the edge where the wait count would reach TIMEOUT,
  // so reg_req stays high for exactly TIMEOUT cycles.
  localparam logic [7:0]                TO_LAST    = 8'(TIMEOUT - 1);

  state_t                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      wr_q, wr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      ready_q, ready_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      halt_q, halt_d;
  logic                      resume_q, resume_d;
  logic                      step_q, step_d;
  logic                      reg_req_q, reg_req_d;
  logic                      reg_we_q, reg_we_d;
  logic [4:0]                reg_idx_q, reg_idx_d;
  logic [DATA_WIDTH-1:0]     reg_wdata_q, reg_wdata_d;
  logic [4:0]                gpr_idx_q, gpr_idx_d;
  logic [DATA_WIDTH-1:0]     scratch_q, scratch_d;
  logic                      err_q, err_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     rd_val;

  always_comb begin
    rd_val = '0;
    case (apb_addr)
      A_ID:      rd_val = DATA_WIDTH'(ID_VALUE);
      A_STATUS:  rd_val = DATA_WIDTH'({reg_req_q, err_q, core_halted});
      A_PC:      rd_val = DATA_WIDTH'(core_pc);
      A_GPR_IDX: rd_val = DATA_WIDTH'(gpr_idx_q);
      A_SCRATCH: rd_val = scratch_q;
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    ready_d     = ready_q;
    rdata_d     = rdata_q;
    halt_d      = 1'b0;
    resume_d    = 1'b0;
    step_d      = 1'b0;
    reg_req_d   = reg_req_q;
    reg_we_d    = reg_we_q;
    reg_idx_d   = reg_idx_q;
    reg_wdata_d = reg_wdata_q;
    gpr_idx_d   = gpr_idx_q;
    scratch_d   = scratch_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (apb_sel && !apb_enable) begin
          addr_d  = apb_addr;
          wr_d    = apb_wr_rd;
          wdata_d = apb_wdata;
          if (apb_addr == A_GPR_DATA && core_halted) begin
            state_d     = S_WAIT_CORE;
            reg_req_d   = 1'b1;
            reg_we_d    = apb_wr_rd;
            reg_idx_d   = gpr_idx_q;
            reg_wdata_d = apb_wdata;
            cnt_d       = '0;
          end else begin
            state_d = S_ACCESS;
            ready_d = 1'b1;
            rdata_d = rd_val;
            if (apb_addr == A_GPR_DATA) err_d = 1'b1;
          end
        end
      end
      S_WAIT_CORE: begin
        if (reg_ack) begin
          reg_req_d = 1'b0;
          rdata_d   = reg_we_q ? '0 : reg_rdata;
          ready_d   = 1'b1;
          state_d   = S_ACCESS;
        end else if (cnt_q >= TO_LAST) begin
          reg_req_d = 1'b0;
          err_d     = 1'b1;
          rdata_d   = '0;
          ready_d   = 1'b1;
          state_d   = S_ACCESS;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ACCESS: begin
        if (!apb_sel) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
        end else if (apb_enable && ready_q) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
          if (wr_q) begin
            case (addr_q)
              A_CTRL: begin
                // Halt wins over a simultaneous resume.
                if (wdata_q[0])      halt_d   = 1'b1;
                else if (wdata_q[1]) resume_d = 1'b1;
                if (wdata_q[2]) begin
                  if (core_halted) step_d = 1'b1;
                  else             err_d  = 1'b1;
                end
              end
              A_STATUS:  if (wdata_q[1]) err_d = 1'b0;
              A_GPR_IDX: gpr_idx_d = wdata_q[4:0];
              A_SCRATCH: scratch_d = wdata_q;
              default: ;
            endcase
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      halt_q      <= 1'b0;
      resume_q    <= 1'b0;
      step_q      <= 1'b0;
      reg_req_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_idx_q   <= '0;
      reg_wdata_q <= '0;
      gpr_idx_q   <= '0;
      scratch_q   <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      halt_q      <= halt_d;
      resume_q    <= resume_d;
      step_q      <= step_d;
      reg_req_q   <= reg_req_d;
      reg_we_q    <= reg_we_d;
      reg_idx_q   <= reg_idx_d;
      reg_wdata_q <= reg_wdata_d;
      gpr_idx_q   <= gpr_idx_d;
      scratch_q   <= scratch_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign apb_ready  = ready_q;
  assign apb_rdata  = rdata_q;
  assign halt_req   = halt_q;
  assign resume_req = resume_q;
  assign step_req   = step_q;
  assign reg_req    = reg_req_q;
  assign reg_we     = reg_we_q;
  assign reg_idx    = reg_idx_q;
  assign reg_wdata  = reg_wdata_q;

endmodule

// File: tb/tb_dbg_apb_core_slave.sv
// Directed bench for dbg_apb_core_slave: register file, run control,
// GPR side channel, timeout and reset abort.
module tb_dbg_apb_core_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  apb_addr;
  logic        apb_sel, apb_enable, apb_wr_rd;
  logic [31:0] apb_wdata;
  logic        apb_ready;
  logic [31:0] apb_rdata;
  logic        halt_req, resume_req, step_req;
  logic        core_halted;
  logic [31:0] core_pc;
  logic        reg_req, reg_we;
  logic [4:0]  reg_idx;
  logic [31:0] reg_wdata;
  logic        reg_ack;
  logic [31:0] reg_rdata;

  int total = 0;
  int bad   = 0;
  int req_seen = 0;

  dbg_apb_core_slave #(
    .ADDR_WIDTH(32), .APB_ADDR_WIDTH(5), .DATA_WIDTH(32),
    .ID_VALUE(32'h7AC1_0001), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .apb_addr(apb_addr), .apb_sel(apb_sel), .apb_enable(apb_enable),
    .apb_wr_rd(apb_wr_rd), .apb_wdata(apb_wdata),
    .apb_ready(apb_ready), .apb_rdata(apb_rdata),
    .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
    .core_halted(core_halted), .core_pc(core_pc),
    .reg_req(reg_req), .reg_we(reg_we), .reg_idx(reg_idx), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (reg_req) req_seen++;

  // Full APB transfer; caller is positioned 1 ns after a rising edge and
  // returns 1 ns after the commit edge.
  task automatic apb_xfer(input logic [4:0] a, input logic wr, input logic [31:0] wd,
                          output logic [31:0] rd, output int waits);
    apb_sel = 1'b1; apb_enable = 1'b0; apb_addr = a; apb_wr_rd = wr; apb_wdata = wd;
    @(posedge clk); #1;
    apb_enable = 1'b1;
    waits = 0;
    while (!apb_ready && waits < 400) begin @(posedge clk); #1; waits++; end
    if (waits >= 400) begin
      total++; bad++;
      $display("FAIL xfer_timeout addr=%0d ready=%b required=1", a, apb_ready);
    end
    rd = apb_rdata;
    @(posedge clk); #1;
    apb_sel = 1'b0; apb_enable = 1'b0; apb_wr_rd = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd; int w;
    rst_n = 1'b0; apb_addr = '0; apb_sel = 0; apb_enable = 0; apb_wr_rd = 0;
    apb_wdata = '0; core_halted = 0; core_pc = 32'h0000_4000; reg_ack = 0; reg_rdata = '0;
    repeat (2) @(posedge clk); #1;
    total++;
    if ({apb_ready, apb_rdata, halt_req, resume_req, step_req, reg_req, reg_we, reg_idx, reg_wdata} !== '0) begin
      bad++; $display("FAIL reset_outputs ready=%b rdata=%h req=%b required all 0", apb_ready, apb_rdata, reg_req);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(5'd0, 1'b0, '0, rd, w);
    total++;
    if (w !== 0) begin bad++; $display("FAIL id_waits got=%0d required=0", w); end
    total++;
    if (rd !== 32'h7AC1_0001) begin bad++; $display("FAIL id_read got=%h required=7ac10001", rd); end
    apb_xfer(5'd3, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h0000_4000) begin bad++; $display("FAIL pc_read got=%h required=00004000", rd); end
  endtask

  task automatic test_scratch;
    logic [31:0] rd; int w;
    apb_xfer(5'd6, 1'b1, 32'hA5A5_5A5A, rd, w);
    apb_xfer(5'd6, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'hA5A5_5A5A) begin bad++; $display("FAIL scratch_rb got=%h required=a5a55a5a", rd); end
    apb_xfer(5'd9, 1'b1, 32'hFFFF_FFFF, rd, w);
    apb_xfer(5'd9, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h required=0", rd); end
    apb_xfer(5'd2, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL status_no_err got=%h required=0", rd); end
  endtask

  task automatic test_ctrl;
    logic [31:0] rd; int w;
    apb_xfer(5'd1, 1'b1, 32'h3, rd, w);
    total++;
    if ({halt_req, resume_req, step_req} !== 3'b100) begin
      bad++; $display("FAIL ctrl_halt_pulse got=%b required=100", {halt_req, resume_req, step_req});
    end
    @(posedge clk); #1;
    total++;
    if (halt_req !== 1'b0) begin bad++; $display("FAIL ctrl_pulse_width got=%b required=0", halt_req); end
    core_halted = 1'b1;
    apb_xfer(5'd1, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL ctrl_reads0 got=%h required=0", rd); end
    apb_xfer(5'd2, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h1) begin bad++; $display("FAIL status_halted got=%h required=1", rd); end
    apb_xfer(5'd1, 1'b1, 32'h4, rd, w);
    total++;
    if ({halt_req, resume_req, step_req} !== 3'b001) begin
      bad++; $display("FAIL ctrl_step_pulse got=%b required=001", {halt_req, resume_req, step_req});
    end
  endtask

  task automatic test_gpr_read;
    logic [31:0] rd; int w; int n;
    apb_xfer(5'd4, 1'b1, 32'hFFFF_FFE7, rd, w);
    apb_xfer(5'd4, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h7) begin bad++; $display("FAIL gpr_idx_rb got=%h required=7", rd); end
    apb_sel = 1'b1; apb_enable = 1'b0; apb_addr = 5'd5; apb_wr_rd = 1'b0;
    @(posedge clk); #1;
    apb_enable = 1'b1;
    total++;
    if ({reg_req, reg_we, reg_idx, apb_ready} !== {1'b1, 1'b0, 5'd7, 1'b0}) begin
      bad++; $display("FAIL gpr_req_fields req=%b we=%b idx=%0d ready=%b required 1 0 7 0",
                      reg_req, reg_we, reg_idx, apb_ready);
    end
    n = 1;
    repeat (3) begin @(posedge clk); #1; if (reg_req) n++; end
    reg_ack = 1'b1; reg_rdata = 32'h1234;
    @(posedge clk); #1;
    reg_ack = 1'b0; reg_rdata = 32'hDEAD_0000;
    total++;
    if (n !== 4) begin bad++; $display("FAIL gpr_req_len got=%0d required=4", n); end
    total++;
    if ({reg_req, apb_ready} !== 2'b01 || apb_rdata !== 32'h1234) begin
      bad++; $display("FAIL gpr_read_done req=%b ready=%b rdata=%h required 0 1 00001234",
                      reg_req, apb_ready, apb_rdata);
    end
    @(posedge clk); #1;
    apb_sel = 1'b0; apb_enable = 1'b0;
    total++;
    if (apb_ready !== 1'b0 || apb_rdata !== 32'h1234) begin
      bad++; $display("FAIL gpr_commit ready=%b rdata=%h required 0 00001234", apb_ready, apb_rdata);
    end
  endtask

  task automatic test_running;
    logic [31:0] rd; int w; int seen0;
    core_halted = 1'b0;
    seen0 = req_seen;
    apb_xfer(5'd5, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h0 || req_seen != seen0) begin
      bad++; $display("FAIL gpr_running rdata=%h req_cycles=%0d required 0 0", rd, req_seen - seen0);
    end
    apb_xfer(5'd2, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h2) begin bad++; $display("FAIL status_err got=%h required=2", rd); end
    apb_xfer(5'd2, 1'b1, 32'h2, rd, w);
    apb_xfer(5'd2, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL status_w1c got=%h required=0", rd); end
    apb_xfer(5'd1, 1'b1, 32'h4, rd, w);
    total++;
    if (step_req !== 1'b0) begin bad++; $display("FAIL step_running got=%b required=0", step_req); end
    apb_xfer(5'd2, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h2) begin bad++; $display("FAIL step_err got=%h required=2", rd); end
    apb_xfer(5'd1, 1'b1, 32'h2, rd, w);
    total++;
    if ({halt_req, resume_req} !== 2'b01) begin
      bad++; $display("FAIL resume_running got=%b required=01", {halt_req, resume_req});
    end
    apb_xfer(5'd2, 1'b1, 32'h2, rd, w);
  endtask

  task automatic test_timeout;
    logic [31:0] rd; int w; int n;
    core_halted = 1'b1;
    apb_sel = 1'b1; apb_enable = 1'b0; apb_addr = 5'd5; apb_wr_rd = 1'b1; apb_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    apb_enable = 1'b1;
    total++;
    if ({reg_req, reg_we} !== 2'b11 || reg_wdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL gpr_wr_req req=%b we=%b wdata=%h required 1 1 deadbeef", reg_req, reg_we, reg_wdata);
    end
    n = 1;
    while (reg_req && n < 400) begin @(posedge clk); #1; if (reg_req) n++; end
    total++;
    if (n !== 255) begin bad++; $display("FAIL timeout_len got=%0d required=255", n); end
    total++;
    if (apb_ready !== 1'b1 || apb_rdata !== 32'h0) begin
      bad++; $display("FAIL timeout_ready ready=%b rdata=%h required 1 0", apb_ready, apb_rdata);
    end
    @(posedge clk); #1;
    apb_sel = 1'b0; apb_enable = 1'b0; apb_wr_rd = 1'b0;
    reg_ack = 1'b1; reg_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    reg_ack = 1'b0;
    apb_xfer(5'd2, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h3 || w !== 0) begin
      bad++; $display("FAIL timeout_status got=%h waits=%0d required 3 0", rd, w);
    end
    apb_xfer(5'd2, 1'b1, 32'h2, rd, w);
  endtask

  task automatic test_abort;
    logic [31:0] rd; int w;
    apb_xfer(5'd6, 1'b1, 32'h1111_2222, rd, w);
    apb_sel = 1'b1; apb_enable = 1'b0; apb_addr = 5'd6; apb_wr_rd = 1'b1; apb_wdata = 32'hFFFF_0000;
    @(posedge clk); #1;
    apb_sel = 1'b0;
    @(posedge clk); #1;
    apb_wr_rd = 1'b0;
    apb_xfer(5'd6, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h1111_2222) begin bad++; $display("FAIL sel_drop_nowrite got=%h required=11112222", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; int w;
    apb_xfer(5'd4, 1'b1, 32'h9, rd, w);
    apb_sel = 1'b1; apb_enable = 1'b0; apb_addr = 5'd5; apb_wr_rd = 1'b1; apb_wdata = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    apb_enable = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({reg_req, apb_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_abort req=%b ready=%b required 0 0", reg_req, apb_ready);
    end
    apb_sel = 1'b0; apb_enable = 1'b0; apb_wr_rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(5'd6, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h0 || w !== 0) begin bad++; $display("FAIL reset_scratch got=%h waits=%0d required 0 0", rd, w); end
    apb_xfer(5'd4, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL reset_gpr_idx got=%h required=0", rd); end
    apb_xfer(5'd2, 1'b0, '0, rd, w);
    total++;
    if (rd !== 32'h1) begin bad++; $display("FAIL reset_status got=%h required=1", rd); end
  endtask

  initial begin
    test_reset;
    test_scratch;
    test_ctrl;
    test_gpr_read;
    test_running;
    test_timeout;
    test_abort;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/dbg_apb_core_slave.md
Name: dbg_apb_core_slave

Overview:
- APB responder at the core end of the debug access path. It terminates transfers from the debug APB bus and returns rdata/ready to the bus's per-core slave mux.
- Exposes a small debug register file: ID, run control, status, PC, GPR index/data, scratch.
- Run control and GPR accesses go to the core through a req/ack side channel.

Parameters:
- ADDR_WIDTH, 32, width of core PC.
- APB_ADDR_WIDTH, 5, APB address width; address is a word index (0..31).
- DATA_WIDTH, 32, APB rdata/wdata width.
- ID_VALUE, 32'h7AC1_0001, read-only ID register value.
- TIMEOUT, 255, max cycles waiting for reg_ack (8-bit counter).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- apb_addr  in  APB_ADDR_WIDTH  register index
- apb_sel  in  1  slave selected
- apb_enable  in  1  access phase
- apb_wr_rd  in  1  1=write, 0=read
- apb_wdata  in  DATA_WIDTH  write data
- apb_ready  out  1  transfer complete (registered)
- apb_rdata  out  DATA_WIDTH  read data (registered, valid when apb_ready)
- halt_req  out  1  one-cycle halt pulse
- resume_req  out  1  one-cycle resume pulse
- step_req  out  1  one-cycle single-step pulse
- core_halted  in  1  core is halted
- core_pc  in  ADDR_WIDTH  current PC
- reg_req  out  1  GPR access request, held until reg_ack
- reg_we  out  1  GPR write (valid with reg_req)
- reg_idx  out  5  GPR index
- reg_wdata  out  DATA_WIDTH  GPR write data
- reg_ack  in  1  one-cycle completion pulse from core
- reg_rdata  in  DATA_WIDTH  GPR read data (valid with reg_ack)

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-low: the clock port is clk, the reset port is rst_n.
- Reset clears all outputs, FSM=IDLE, GPR_IDX=0, SCRATCH=0, err=0.
- Reset mid-transfer aborts it: reg_req drops immediately and no write commits.

Register map (index):
- 0 ID: RO, returns ID_VALUE.
- 1 CTRL: WO, reads 0. Write bit0=halt, bit1=resume, bit2=step.
- 2 STATUS: RO except bit1. bit0=core_halted (live), bit1=err sticky (W1C), bit2=busy (reg_req).
- 3 PC: RO, core_pc zero-extended/truncated to DATA_WIDTH.
- 4 GPR_IDX: RW, bits[4:0], upper bits read 0.
- 5 GPR_DATA: read/write triggers a core GPR access.
- 6 SCRATCH: RW, full width.
- 7..31: read 0, write ignored, no error.

FSM states: IDLE, ACCESS, WAIT_CORE.
- IDLE: on sel=1 & enable=0 (setup), latch addr/wr_rd/wdata.
  - GPR_DATA with core_halted=1: go to WAIT_CORE; reg_req<=1, reg_we=wr_rd, reg_idx=GPR_IDX, reg_wdata=wdata.
  - Otherwise: go to ACCESS; ready<=1, rdata<=register value.
  - Result: zero wait states for simple registers (ready high in the first access cycle).
- GPR_DATA with core_halted=0: no core access, rdata=0, err<=1, goes to ACCESS as a simple register.
- WAIT_CORE: hold reg_req/reg_we/reg_idx/reg_wdata stable.
  - On reg_ack: reg_req<=0, rdata<=reg_rdata (reads) or 0 (writes), ready<=1, go to ACCESS.
  - If the wait counter reaches TIMEOUT without ack: reg_req<=0, err<=1, rdata<=0, ready<=1, go to ACCESS.
  - Wait counter counts cycles in WAIT_CORE, saturating.
- ACCESS: on sel & enable & ready, the transfer commits, ready<=0, go to IDLE.
  - Writes to CTRL, GPR_IDX, SCRATCH and STATUS-W1C take effect at the commit edge.
  - If sel drops before commit (protocol violation): go to IDLE, ready<=0, no write effect.
- rdata holds its last value after ready drops.

CTRL pulses:
- Asserted for exactly one cycle, in the cycle after the commit edge.
- halt and resume written together: only halt_req fires.
- step when core_halted=0: no pulse, err<=1.
- resume when already running: pulse anyway (core ignores it).

Late ack: reg_ack arriving outside WAIT_CORE is ignored.

Test Plan:
- Reset, then read idx 0 -> ready in first access cycle, rdata=0x7AC1_0001; all outputs 0 during reset.
- Write SCRATCH=0xA5A5_5A5A, read back -> 0xA5A5_5A5A. Write idx 9 then read idx 9 -> 0, err stays 0.
- Write CTRL=0x3 -> single halt_req pulse one cycle after commit, no resume_req. Assert core_halted, read STATUS -> 0x1.
- With halted: write GPR_IDX=7, read GPR_DATA, core acks after 4 cycles with 0x1234 -> reg_req high 4 cycles with reg_idx=7, reg_we=0; ready after ack; rdata=0x1234.
- With core running: read GPR_DATA -> no reg_req, rdata=0, STATUS=0x2. Write STATUS=0x2 -> STATUS=0x0. Step while running -> no step_req, err=1.
- Halted, GPR write with no ack -> reg_req drops after 255 cycles, ready=1, err=1. A second run with rst_n low mid-WAIT_CORE -> reg_req=0 immediately, FSM IDLE, SCRATCH=0.
